// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10 over a valid/ready
// handshake, computing one FIPS-197 expansion step per accepted key.
// Optional macro AES_KEY_STORE_EN adds an 11-entry round-key store with a
// registered read port (rd_idx/rd_key) for reverse-order key reads.
//
// state | meaning
// IDLE  | waiting for start, no key presented
// EMIT  | rk_out/rk_index valid, advancing one round per handshake
module aes_key_expand #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [3:0]   rk_index,
    output logic [127:0] rk_out,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    // S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = {8'hff - b, 3'b000};
        return SBOX[base +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t       state;
    state_t       next_state;
    logic         load;
    logic         advance;
    logic         finish;
    logic         hs;
    logic [7:0]   rcon;
    logic [7:0]   rcon_next;
    logic [127:0] next_key;

    assign hs   = rk_valid & rk_ready;
    assign busy = (state == EMIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and step control; start is only honoured from IDLE.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = EMIT;
                    load       = 1'b1;
                end
            end
            EMIT: begin
                if (hs) begin
                    if (rk_index == LAST_IDX) begin
                        next_state = IDLE;
                        finish     = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // One key-expansion step from the key currently presented.
    always_comb begin
        logic [31:0] w3;
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        w3        = rk_out[31:0];
        t         = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
        n0        = rk_out[127:96] ^ t;
        n1        = rk_out[95:64] ^ n0;
        n2        = rk_out[63:32] ^ n1;
        n3        = w3 ^ n2;
        next_key  = {n0, n1, n2, n3};
        rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end

    // Round-key output registers; last key and index are held after finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_valid <= 1'b0;
            rk_index <= '0;
            rk_out   <= '0;
            rcon     <= 8'h01;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                rk_out   <= key_in;
                rk_index <= '0;
                rk_valid <= 1'b1;
                rcon     <= 8'h01;
            end else if (advance) begin
                rk_out   <= next_key;
                rk_index <= rk_index + 4'd1;
                rcon     <= rcon_next;
            end else if (finish) begin
                rk_valid <= 1'b0;
            end
        end
    end

`ifdef AES_KEY_STORE_EN
    logic [127:0] key_store [0:NUM_ROUNDS];

    // Capture each round key as it is handshaken; registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) key_store[i] <= '0;
            rd_key <= '0;
        end else begin
            if (hs) key_store[rk_index] <= rk_out;
            if (rd_idx <= LAST_IDX) rd_key <= key_store[rd_idx];
            else                    rd_key <= '0;
        end
    end
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^rd_idx;
    assign rd_key        = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: table of keys with known round
// keys, scoreboard fed by an independent key-schedule model, plus sequences
// for restart-while-busy, mid-run reset and start on the final handshake.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [3:0]   rk_index;
    logic [127:0] rk_out;
    logic         busy;
    logic         done;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    aes_key_expand dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in),
        .rk_ready(rk_ready), .rk_valid(rk_valid), .rk_index(rk_index),
        .rk_out(rk_out), .busy(busy), .done(done), .rd_idx(rd_idx),
        .rd_key(rd_key)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    typedef struct {
        logic [127:0] key;
        int           mode;
        bit           chk1;
        logic [127:0] rk1;
        bit           chk10;
        logic [127:0] rk10;
    } vec_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] SEQ_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_RK1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] SEQ_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;

    int           checks = 0;
    int           errors = 0;
    exp_t         sb_q[$];
    logic [7:0]   msbox [0:255];
    logic [127:0] mk [0:10];
    logic [127:0] got [0:10];
    int           hs_cnt;
    int           done_cnt;
    bit           prev_stall;
    logic [127:0] prev_out;
    logic [3:0]   prev_idx;
    vec_t         vecs [5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse and affine map, not a copied table.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
            msbox[b] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                     ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic model_keys(input logic [127:0] key);
        logic [7:0]  rc;
        logic [31:0] r;
        logic [31:0] t;
        logic [31:0] n0, n1, n2, n3;
        mk[0] = key;
        rc = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            r  = {mk[i-1][23:0], mk[i-1][31:24]};
            t  = {msbox[r[31:24]], msbox[r[23:16]], msbox[r[15:8]], msbox[r[7:0]]} ^ {rc, 24'h0};
            n0 = mk[i-1][127:96] ^ t;
            n1 = mk[i-1][95:64] ^ n0;
            n2 = mk[i-1][63:32] ^ n1;
            n3 = mk[i-1][31:0] ^ n2;
            mk[i] = {n0, n1, n2, n3};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (rk_valid === 1'b1 && rk_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_key actual_idx=%0d expected=none", rk_index);
            end else begin
                e = sb_q.pop_front();
                check("hs_idx", {124'h0, rk_index}, {124'h0, e.idx});
                check("hs_key", rk_out, e.key);
                if (rk_index <= 4'd10) got[rk_index] = rk_out;
                hs_cnt++;
            end
        end
        if (prev_stall) begin
            check("stall_key", rk_out, prev_out);
            check("stall_idx", {124'h0, rk_index}, {124'h0, prev_idx});
            check("stall_valid", {127'h0, rk_valid}, 128'h1);
        end
        prev_stall = (rk_valid === 1'b1) && !rk_ready && !rst;
        prev_out   = rk_out;
        prev_idx   = rk_index;
        if (done === 1'b1) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_key(input logic [127:0] key, input int mode, input int poke_at,
                           input int rst_at, input bit final_start);
        int n;
        bit aborted;
        model_keys(key);
        for (int i = 0; i <= 10; i++) begin
            sb_q.push_back('{idx: 4'(i), key: mk[i]});
            got[i] = 'x;
        end
        hs_cnt   = 0;
        done_cnt = 0;
        rk_ready = 1'b0;
        start    = 1'b1;
        key_in   = key;
        cycle();
        check("latency_valid", {127'h0, rk_valid}, 128'h1);
        check("latency_idx", {124'h0, rk_index}, 128'h0);
        check("busy_on", {127'h0, busy}, 128'h1);
        n = 0;
        aborted = 1'b0;
        while (hs_cnt < 11 && n < 200 && !aborted) begin
            start    = 1'b0;
            key_in   = {$urandom, $urandom, $urandom, $urandom};
            rk_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (poke_at >= 0 && int'(rk_index) == poke_at) begin
                start  = 1'b1;
                key_in = '0;
            end
            if (final_start && rk_index == 4'd10) begin
                rk_ready = 1'b1;
                start    = 1'b1;
            end
            if (rst_at >= 0 && int'(rk_index) == rst_at) rst = 1'b1;
            cycle();
            if (rst) begin
                rst     = 1'b0;
                aborted = 1'b1;
            end
            n++;
        end
        start = 1'b0;
        if (aborted) begin
            check("abort_valid", {127'h0, rk_valid}, 128'h0);
            check("abort_idx", {124'h0, rk_index}, 128'h0);
            check("abort_key", rk_out, 128'h0);
            check("abort_busy", {127'h0, busy}, 128'h0);
            check("abort_done", {127'h0, done}, 128'h0);
            check("abort_rd_key", rd_key, 128'h0);
            sb_q.delete();
            cycle();
            check("abort_no_done", {127'h0, done}, 128'h0);
            check("abort_idle", {127'h0, busy}, 128'h0);
        end else if (hs_cnt < 11) begin
            checks++;
            errors++;
            $display("FAIL timeout actual_keys=%0d expected=11", hs_cnt);
            sb_q.delete();
        end else begin
            check("done_pulse", {127'h0, done}, 128'h1);
            check("done_busy", {127'h0, busy}, 128'h0);
            check("done_valid", {127'h0, rk_valid}, 128'h0);
            check("done_idx_hold", {124'h0, rk_index}, 128'd10);
            check("done_key_hold", rk_out, mk[10]);
            rk_ready = 1'b1;
            cycle();
            check("done_once", {127'h0, done}, 128'h0);
            check("idle_busy", {127'h0, busy}, 128'h0);
            check("idle_valid", {127'h0, rk_valid}, 128'h0);
            check("done_count", 128'(done_cnt), 128'd1);
            check("sb_drained", 128'(sb_q.size()), 128'd0);
        end
    endtask

    task automatic read_store(input logic [3:0] idx, input logic [127:0] exp);
        rk_ready = 1'b0;
        start    = 1'b0;
        rd_idx   = idx;
        cycle();
        check("rd_key", rd_key, exp);
    endtask

    initial begin
        vecs[0] = '{key: FIPS_KEY, mode: 0, chk1: 1'b1, rk1: FIPS_RK1, chk10: 1'b1, rk10: FIPS_RK10};
        vecs[1] = '{key: FIPS_KEY, mode: 1, chk1: 1'b1, rk1: FIPS_RK1, chk10: 1'b1, rk10: FIPS_RK10};
        vecs[2] = '{key: SEQ_KEY, mode: 0, chk1: 1'b1, rk1: SEQ_RK1, chk10: 1'b1, rk10: SEQ_RK10};
        vecs[3] = '{key: 128'h0, mode: 1, chk1: 1'b1, rk1: ZERO_RK1, chk10: 1'b0, rk10: 128'h0};
        vecs[4] = '{key: {4{32'hffffffff}}, mode: 1, chk1: 1'b0, rk1: 128'h0, chk10: 1'b0, rk10: 128'h0};

        rst        = 1'b1;
        start      = 1'b0;
        rk_ready   = 1'b0;
        key_in     = '0;
        rd_idx     = 4'd0;
        prev_stall = 1'b0;
        hs_cnt     = 0;
        done_cnt   = 0;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {127'h0, rk_valid}, 128'h0);
        check("rst_idx", {124'h0, rk_index}, 128'h0);
        check("rst_key", rk_out, 128'h0);
        check("rst_busy", {127'h0, busy}, 128'h0);
        check("rst_done", {127'h0, done}, 128'h0);
        check("rst_rd_key", rd_key, 128'h0);
        rst = 1'b0;
        cycle();

        for (int v = 0; v < 5; v++) begin
            run_key(vecs[v].key, vecs[v].mode, -1, -1, 1'b0);
            if (vecs[v].chk1) check("vec_rk1", got[1], vecs[v].rk1);
            if (vecs[v].chk10) check("vec_rk10", got[10], vecs[v].rk10);
        end

        // start with key 0 while busy at round 4 must not disturb the run
        run_key(FIPS_KEY, 1, 4, -1, 1'b0);
        check("poke_rk10", got[10], FIPS_RK10);

`ifdef AES_KEY_STORE_EN
        read_store(4'd10, FIPS_RK10);
        read_store(4'd0, FIPS_KEY);
        read_store(4'd1, FIPS_RK1);
        read_store(4'd15, 128'h0);
`else
        read_store(4'd10, 128'h0);
`endif

        // reset at round 6 aborts; a fresh start then runs cleanly
        run_key(FIPS_KEY, 0, -1, 6, 1'b0);
`ifdef AES_KEY_STORE_EN
        read_store(4'd3, 128'h0);
`endif
        run_key(SEQ_KEY, 1, -1, -1, 1'b0);
        check("post_rst_rk10", got[10], SEQ_RK10);

        // start coincident with the final handshake is ignored
        run_key(128'h0, 0, -1, -1, 1'b1);
        check("zero_rk1", got[1], ZERO_RK1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule. Sits directly upstream of the encryption round datapath and supplies the round key consumed by AddRoundKey after each round.
- Takes one 128-bit cipher key and emits round keys 0..10 in order, one per accepted handshake, using a valid/ready interface.
- Computes one FIPS-197 key-expansion step per cycle with an internal 4-byte S-box.

Parameters:
- NUM_ROUNDS, 10, number of expansion steps after round key 0; fixed at 10 for AES-128, the only supported value.

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new expansion; sampled only in IDLE
- key_in  input  128  cipher key; captured on the cycle start is accepted; byte 0 = bits [127:120]
- rk_ready  input  1  downstream can accept rk_out this cycle
- rk_valid  output  1  rk_out / rk_index hold a valid round key
- rk_index  output  4  round number of rk_out, 0..10
- rk_out  output  128  current round key, same byte order as key_in
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after round key 10 is accepted
- rd_idx  input  4  store read index (see Optional Feature)
- rd_key  output  128  store read data (see Optional Feature)

Behaviour:
- Reset, applied on the clk edge while rst=1: state=IDLE; rk_valid=0, rk_index=0, rk_out=0, busy=0, done=0, rd_key=0; rcon register=8'h01.
- States: IDLE, EMIT.
- IDLE -> EMIT when start=1.
  - Next cycle: rk_out=key_in, rk_index=0, rk_valid=1, busy=1, rcon=8'h01.
  - Latency: start to first valid key = 1 cycle.
- EMIT, handshake = rk_valid & rk_ready:
  - No handshake: rk_out, rk_index and rk_valid hold unchanged (no drop, no advance).
  - Handshake with rk_index<10: next cycle rk_out = expand(rk_out, rcon), rk_index+1, rcon = xtime(rcon).
  - Expansion, with w0..w3 as the 32-bit words of rk_out (w0 = MSBs):
    - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
    - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - xtime: left shift 1; if bit 7 was set, XOR 8'h1b. This gives rcon 01,02,04,08,10,20,40,80,1b,36.
  - Handshake with rk_index=10: next state IDLE; rk_valid=0, busy=0, done=1 for exactly one cycle; rk_out and rk_index keep their last values.
- Throughput: one round key per cycle when rk_ready is held high; 11 keys in 11 cycles.
- start while busy: ignored; no restart, no corruption of the sequence in flight.
- start in the same cycle as the final handshake: ignored (state still EMIT). Accepted from IDLE on the next cycle.
- Reset mid-operation: immediately aborts to reset values; no done pulse.
- key_in is don't-care except on the start-accept cycle.

Optional Feature:
- Macro: AES_KEY_STORE_EN.
- Defined:
  - Internal 11x128 register file; round key i is written on the cycle it is handshaken.
  - rd_key registered: rd_key = store[rd_idx] one cycle after rd_idx is presented.
  - rd_idx>10 returns 0.
  - Contents stay valid until overwritten by the next expansion; reset clears all entries to 0.
  - Serves reverse-order key reads for the decryption path.
- Undefined: no storage is inferred, rd_idx is ignored, and rd_key is constant 0.

Test Plan:
- rst, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk_index 0..10 on consecutive cycles; index0=2b7e1516..., index1=a0fafe1788542cb123a339392a6c7605, index10=d014f9a8c9ee2589e13f0cc8b6630ca6; done pulses once; busy=0 after.
- Same key, rk_ready toggled randomly -> identical 11-key sequence; rk_out stable every stalled cycle; no index skipped.
- start pulsed at rk_index=4 with key_in=0 -> ignored; remaining keys still match the FIPS-197 vector.
- rst asserted at rk_index=6 -> next cycle all outputs 0 and state IDLE; a new start with key_in=000102030405060708090a0b0c0d0e0f yields index10=13111d7fe3944a17f307a78b4d2b30c5.
- All-zero key -> index1=62636363626363636263636362636363.
- AES_KEY_STORE_EN defined: after the FIPS-197 run, rd_idx=10 -> d014f9a8...0ca6 one cycle later; rd_idx=0 -> 2b7e1516...4f3c; rd_idx=15 -> 0.
